johnson_step_sequencer: RTL
===========================

# johnson_step_sequencer

Command-driven sequencer that owns a WIDTH-bit Johnson (twisted-ring) phase register and steps it a programmed number of positions in either direction. It replaces free-running Johnson counters wherever phase generation must start, pause, stop or clear under control-logic command. It accepts one command at a time over a valid/ready handshake, reports progress, and pulses `done` on completion. Downstream logic consumes `q`, the decoded phase index or the one-hot phase.

## Interface
- `WIDTH`, 4: Johnson register width, ≥2; 2*WIDTH legal states.
- `CNT_W`, 8: width of the step count.
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command. High only in IDLE.
- `cmd_steps`  in  CNT_W  number of steps to perform (0 is legal).
- `cmd_dir`  in  1  0 = forward: q <= {~q[0], q[W-1:1]}. 1 = reverse: q <= {q[W-2:0], ~q[W-1]}.
- `cmd_clear`  in  1  force q to 0 at acceptance, before stepping.
- `pause`  in  1  hold stepping while high (RUN only).
- `abort`  in  1  terminate the active command.
- `q`  out  WIDTH  Johnson register.
- `phase_idx`  out  $clog2(2*WIDTH)  decoded phase position.
- `phase_onehot`  out  2*WIDTH  bit `phase_idx` set, all others 0.
- `remaining`  out  CNT_W  steps still to perform.
- `busy`  out  1  state is RUN or PAUSE.
- `done`  out  1  single-cycle completion pulse.

## Operation
- The design is clocked only by `clk`. `reset_n` is an asynchronous, active-low reset.
- States are IDLE, RUN, PAUSE and DONE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, the command is accepted: `cmd_dir` is latched and `remaining` <= `cmd_steps`.
  - If `cmd_clear` is set, q <= 0 in the same edge.
  - If `cmd_steps`=0, the next state is DONE; otherwise the next state is RUN.
- RUN:
  - Each cycle, q steps in the latched direction and `remaining` decrements.
  - When a step is taken with `remaining`=1, the next state is DONE and `remaining` becomes 0.
- PAUSE:
  - Entered from RUN when `pause`=1; no step is taken that cycle.
  - Returns to RUN in the cycle `pause`=0. q and `remaining` hold.
  - `pause` is ignored in IDLE and DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Abort:
  - `abort` in RUN or PAUSE goes to IDLE next edge with no step, no `done`, q held and `remaining` cleared to 0.
  - `abort` has priority over `pause` and over the final step.
  - `abort` is ignored in IDLE and DONE.
- Phase decode:
  - If q[0]=0, `phase_idx` = popcount(q).
  - Otherwise, `phase_idx` = 2*WIDTH − popcount(q).
  - Forward steps increment `phase_idx` mod 2*WIDTH; reverse steps decrement it.
  - For WIDTH=4, the forward sequence is 0000→1000→1100→1110→1111→0111→0011→0001→0000 (idx 0..7).
- q never leaves the legal Johnson set: reset and clear load 0, and both step functions preserve legality.
- Width rules:
  - `remaining` never underflows; it is 0 in IDLE after DONE or abort.
  - `cmd_steps` up to 2^CNT_W−1 is legal; wrap-around of the phase is normal.

## Timing
- Reset values: q=0, `phase_idx`=0, `phase_onehot`=…0001, `remaining`=0, `busy`=0, `done`=0, `cmd_ready`=1, state IDLE.
- Reset asserted mid-command returns all of the above immediately, with no `done`.
- Timing of a command accepted at edge k with N≥1 steps:
  - First q change at edge k+1; `busy`=1 from k+1.
  - Last step at edge k+N, assuming no pause.
  - `done`=1 and `busy`=0 in the cycle after edge k+N.
  - `cmd_ready`=1 again after edge k+N+1.
- Each paused cycle delays completion by exactly one cycle.
- With N=0, `done` is high in the cycle after acceptance and q changes only via clear.
- Minimum command-to-command spacing is N+2 cycles.
- `phase_idx` and `phase_onehot` are combinational from q, with no added latency.

## Test plan
- Reset, then `cmd_steps`=5, `cmd_dir`=0, `cmd_clear`=1 → q sequence 1000,1100,1110,1111,0111. `phase_idx` 1..5. `done` pulse 6 cycles after acceptance. `remaining` 5→0.
- Forward 10 steps from 0, WIDTH=4 → wraps past 0001→0000 and ends at q=1100, `phase_idx`=2.
- From q=0111 (idx 5), `cmd_dir`=1, 3 steps, no clear → 1111, 1110, 1100. Final idx 2.
- 6-step command with `pause` high for 3 cycles after step 2 → q and `remaining`=4 frozen, `busy`=1. `done` arrives 3 cycles later than the unpaused case.
- `abort` asserted with `pause` after step 2 of 8 → IDLE next edge, q unchanged, `remaining`=0, no `done`, `cmd_ready`=1.
- `cmd_steps`=0 with `cmd_clear`=1 from q=1110 → q=0000. `done` in the next cycle with no step taken. Then `reset_n` low mid-RUN of a new command → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/johnson_step_sequencer.sv
// Command-driven Johnson (twisted-ring) phase sequencer: steps a WIDTH-bit
// Johnson register a programmed number of positions forward or backward.
module johnson_step_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [CNT_W-1:0]              cmd_steps,
    input  logic                          cmd_dir,
    input  logic                          cmd_clear,
    input  logic                          pause,
    input  logic                          abort,
    output logic [WIDTH-1:0]              q,
    output logic [$clog2(2*WIDTH)-1:0]    phase_idx,
    output logic [2*WIDTH-1:0]            phase_onehot,
    output logic [CNT_W-1:0]              remaining,
    output logic                          busy,
    output logic                          done
);

    localparam int IDX_W = $clog2(2*WIDTH);
    localparam int PH_W  = 2*WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    state_t           state;
    logic             dir;
    logic [WIDTH-1:0] step_q;
    logic [IDX_W-1:0] pop;

    always_comb begin
        step_q = dir ? {q[WIDTH-2:0], ~q[WIDTH-1]} : {~q[0], q[WIDTH-1:1]};
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would chain q/remaining within one edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            q         <= '0;
            remaining <= '0;
            dir       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        dir       <= cmd_dir;
                        remaining <= cmd_steps;
                        if (cmd_clear) q <= '0;
                        state <= (cmd_steps == '0) ? DONE : RUN;
                    end
                end
                RUN, PAUSE: begin
                    // Abort wins over both pause and the final step.
                    if (abort) begin
                        remaining <= '0;
                        state     <= IDLE;
                    end else if (pause) begin
                        state <= PAUSE;
                    end else begin
                        q         <= step_q;
                        remaining <= remaining - CNT_W'(1);
                        state     <= (remaining == CNT_W'(1)) ? DONE : RUN;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RUN) || (state == PAUSE);
    assign done      = (state == DONE);

    // NOTE: every variable driven in always_comb gets a default first so no
    // latch can be inferred.
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + IDX_W'(q[i]);
        end
        // Second half of the ring (q[0]=1) counts back down from 2*WIDTH.
        phase_idx = q[0] ? (IDX_W'(PH_W) - pop) : pop;
    end

    assign phase_onehot = PH_W'(1) << phase_idx;

endmodule
